fsm_seq_checker: RTL and testbench



---
 rtl/fsm_seq_checker.sv | 198 +++++++++++++++++++
 tb/tb_fsm_seq_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fsm_seq_checker.sv
// Response checker for the 5-state ring FSM: tracks the expected state and scores the observed y.
// Define FSM_SEQ_CHECKER_LOG_EN to add first-mismatch capture outputs.
//
// state | meaning
// IDLE  | waiting for a start rising edge
// SYNC  | waiting for y == c0, bounded by SYNC_TIMEOUT
// TRACK | comparing y against c[exp_idx] every cycle
// PASS  | run finished within the error budget (sticky)
// FAIL  | error budget hit or sync timed out (sticky)
module fsm_seq_checker #(
  parameter int unsigned RUN_CYCLES   = 20,
  parameter int unsigned SYNC_TIMEOUT = 8,
  parameter int unsigned MAX_ERRORS   = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       en,
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  input  logic       i4,
  input  logic [2:0] c0,
  input  logic [2:0] c1,
  input  logic [2:0] c2,
  input  logic [2:0] c3,
  input  logic [2:0] c4,
  input  logic [2:0] y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       fail,
  output logic [7:0] err_count,
  output logic [7:0] cycles,
  output logic [2:0] exp_state
`ifdef FSM_SEQ_CHECKER_LOG_EN
  ,
  output logic [7:0] first_err_cycle,
  output logic [2:0] first_err_exp,
  output logic [2:0] first_err_obs
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_TRACK, S_PASS, S_FAIL} state_e;

  localparam logic [7:0] RUN_W  = 8'(RUN_CYCLES);
  localparam logic [7:0] SYNC_W = 8'(SYNC_TIMEOUT);
  localparam logic [8:0] MAX_W  = 9'(MAX_ERRORS);

  state_e     state_q, state_d;
  logic [2:0] exp_idx_q, exp_idx_d;
  logic [7:0] err_count_q, err_count_d;
  logic [7:0] cycles_q, cycles_d;
  logic [7:0] sync_cnt_q, sync_cnt_d;
  logic       start_q, start_d;
  logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d, fail_q, fail_d;
  logic [2:0] c_sel;
  logic       i_sel;
  logic       start_rise, mismatch, run_start;
  logic [8:0] err_sum;
`ifdef FSM_SEQ_CHECKER_LOG_EN
  logic [7:0] first_err_cycle_q, first_err_cycle_d;
  logic [2:0] first_err_exp_q, first_err_exp_d;
  logic [2:0] first_err_obs_q, first_err_obs_d;
`endif

  always_comb begin
    c_sel = c0;
    i_sel = i0;
    case (exp_idx_q)
      3'd1:    begin c_sel = c1; i_sel = i1; end
      3'd2:    begin c_sel = c2; i_sel = i2; end
      3'd3:    begin c_sel = c3; i_sel = i3; end
      3'd4:    begin c_sel = c4; i_sel = i4; end
      default: begin c_sel = c0; i_sel = i0; end
    endcase
  end

  assign start_rise = start & ~start_q;
  assign mismatch   = (y != c_sel);
  assign err_sum    = {1'b0, err_count_q} + {8'd0, mismatch};
  assign run_start  = start_rise &&
                      (state_q == S_IDLE || state_q == S_PASS || state_q == S_FAIL);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      exp_idx_q   <= 3'd0;
      err_count_q <= 8'd0;
      cycles_q    <= 8'd0;
      sync_cnt_q  <= 8'd0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
`ifdef FSM_SEQ_CHECKER_LOG_EN
      first_err_cycle_q <= 8'd0;
      first_err_exp_q   <= 3'd0;
      first_err_obs_q   <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      exp_idx_q   <= exp_idx_d;
      err_count_q <= err_count_d;
      cycles_q    <= cycles_d;
      sync_cnt_q  <= sync_cnt_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
`ifdef FSM_SEQ_CHECKER_LOG_EN
      first_err_cycle_q <= first_err_cycle_d;
      first_err_exp_q   <= first_err_exp_d;
      first_err_obs_q   <= first_err_obs_d;
`endif
    end
  end

  // FAIL is tested before PASS so a mismatch on the last cycle still fails.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_PASS, S_FAIL: if (start_rise) state_d = S_SYNC;
      S_SYNC: begin
        if (y == c0)                          state_d = S_TRACK;
        else if (sync_cnt_q + 8'd1 == SYNC_W) state_d = S_FAIL;
      end
      S_TRACK: begin
        if (err_sum >= MAX_W)                 state_d = S_FAIL;
        else if (cycles_q + 8'd1 == RUN_W)    state_d = S_PASS;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start_d     = start;
    exp_idx_d   = exp_idx_q;
    err_count_d = err_count_q;
    cycles_d    = cycles_q;
    sync_cnt_d  = sync_cnt_q;
`ifdef FSM_SEQ_CHECKER_LOG_EN
    first_err_cycle_d = first_err_cycle_q;
    first_err_exp_d   = first_err_exp_q;
    first_err_obs_d   = first_err_obs_q;
`endif
    if (run_start) begin
      exp_idx_d   = 3'd0;
      err_count_d = 8'd0;
      cycles_d    = 8'd0;
      sync_cnt_d  = 8'd0;
`ifdef FSM_SEQ_CHECKER_LOG_EN
      first_err_cycle_d = 8'd0;
      first_err_exp_d   = 3'd0;
      first_err_obs_d   = 3'd0;
`endif
    end else if (state_q == S_SYNC) begin
      if (y == c0) exp_idx_d  = 3'd0;
      else         sync_cnt_d = sync_cnt_q + 8'd1;
    end else if (state_q == S_TRACK) begin
      err_count_d = err_sum[8] ? 8'hFF : err_sum[7:0];
      cycles_d    = cycles_q + 8'd1;
      if (en && i_sel) exp_idx_d = (exp_idx_q == 3'd4) ? 3'd0 : exp_idx_q + 3'd1;
`ifdef FSM_SEQ_CHECKER_LOG_EN
      if (mismatch && err_count_q == 8'd0) begin
        first_err_cycle_d = cycles_q;
        first_err_exp_d   = c_sel;
        first_err_obs_d   = y;
      end
`endif
    end
  end

  // Flags decode the next state so they line up with state_q after the edge.
  always_comb begin
    busy_d = (state_d == S_SYNC) || (state_d == S_TRACK);
    done_d = (state_d == S_PASS) || (state_d == S_FAIL);
    pass_d = (state_d == S_PASS);
    fail_d = (state_d == S_FAIL);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign err_count = err_count_q;
  assign cycles    = cycles_q;
  assign exp_state = c_sel;
`ifdef FSM_SEQ_CHECKER_LOG_EN
  assign first_err_cycle = first_err_cycle_q;
  assign first_err_exp   = first_err_exp_q;
  assign first_err_obs   = first_err_obs_q;
`endif

endmodule

// File: tb/tb_fsm_seq_checker.sv
// Directed bench for fsm_seq_checker: drives y as an ideal or faulty ring FSM and checks flags/counters.
module tb_fsm_seq_checker;

  logic       clock = 1'b0;
  logic       reset, start, en;
  logic       i0, i1, i2, i3, i4;
  logic [2:0] c0, c1, c2, c3, c4, y;
  logic       busy, done, pass, fail;
  logic [7:0] err_count, cycles;
  logic [2:0] exp_state;
`ifdef FSM_SEQ_CHECKER_LOG_EN
  logic [7:0] first_err_cycle;
  logic [2:0] first_err_exp, first_err_obs;
`endif

  logic [2:0] cv [5];
  logic [4:0] iv;
  int n_checks = 0;
  int n_errors = 0;

  assign {i4, i3, i2, i1, i0} = iv;
  assign c0 = cv[0];
  assign c1 = cv[1];
  assign c2 = cv[2];
  assign c3 = cv[3];
  assign c4 = cv[4];

  always #5 clock = ~clock;

  fsm_seq_checker #(.RUN_CYCLES(20), .SYNC_TIMEOUT(8), .MAX_ERRORS(1)) dut (
    .clock(clock), .reset(reset), .start(start), .en(en),
    .i0(i0), .i1(i1), .i2(i2), .i3(i3), .i4(i4),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .y(y),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .err_count(err_count), .cycles(cycles), .exp_state(exp_state)
`ifdef FSM_SEQ_CHECKER_LOG_EN
    ,
    .first_err_cycle(first_err_cycle), .first_err_exp(first_err_exp),
    .first_err_obs(first_err_obs)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves the DUT in its first SYNC cycle with cleared counters.
  task automatic start_run();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    chk("run_busy", busy, 1);
    chk("run_done", done, 0);
    chk("run_err", err_count, 0);
    chk("run_cycles", cycles, 0);
  endtask

  // mode 0: all advance, 1: held at c0, 2: stuck at index 2. inj_k < 0 means no fault.
  task automatic run_track(input int n, input int mode, input int inj_k, input int inj_val);
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = (mode == 0) ? (k % 5) : (mode == 1) ? 0 : ((k < 2) ? k : 2);
      y = (k == inj_k) ? 3'(inj_val) : cv[idx];
      chk("trk_exp_state", exp_state, cv[idx]);
      chk("trk_cycles", cycles, k);
      chk("trk_busy", busy, 1);
      tick();
    end
  endtask

  task automatic chk_pass(input string tag);
    chk({tag, "_pass"}, pass, 1);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_cycles"}, cycles, 20);
  endtask

  initial begin
    cv[0] = 3'd0; cv[1] = 3'd1; cv[2] = 3'd2; cv[3] = 3'd3; cv[4] = 3'd4;
    iv = 5'b11111;
    en = 1'b1;
    start = 1'b0;
    y = 3'd0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_err", err_count, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_exp_state", exp_state, 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // 1: ideal ring FSM, everything advances
    start_run();
    tick();
    run_track(20, 0, -1, 0);
    chk_pass("t1");
    tick();
    tick();
    chk("t1_start_held_pass", pass, 1);
    chk("t1_start_held_busy", busy, 0);

    // 2: en low, FSM parked at c0
    en = 1'b0;
    y = cv[0];
    start_run();
    chk("t2_pass_cleared", pass, 0);
    tick();
    run_track(20, 1, -1, 0);
    chk_pass("t2");

    // 3: single corrupted y on TRACK cycle 5
    en = 1'b1;
    y = cv[0];
    start_run();
    tick();
    run_track(6, 0, 5, 7);
    chk("t3_fail", fail, 1);
    chk("t3_done", done, 1);
    chk("t3_pass", pass, 0);
    chk("t3_busy", busy, 0);
    chk("t3_err", err_count, 1);
    chk("t3_cycles", cycles, 6);
`ifdef FSM_SEQ_CHECKER_LOG_EN
    chk("t3_first_cycle", first_err_cycle, 5);
    chk("t3_first_exp", first_err_exp, 0);
    chk("t3_first_obs", first_err_obs, 7);
`endif
    tick();
    chk("t3_fail_sticky", fail, 1);

    // 4: y never reaches c0, sync times out after 8 cycles
    y = 3'd3;
    start_run();
`ifdef FSM_SEQ_CHECKER_LOG_EN
    chk("t4_log_cleared", first_err_cycle, 0);
`endif
    for (int j = 1; j < 8; j++) begin
      tick();
      chk("t4_sync_busy", busy, 1);
    end
    tick();
    chk("t4_fail", fail, 1);
    chk("t4_busy", busy, 0);
    chk("t4_cycles", cycles, 0);
    chk("t4_err", err_count, 0);

    // 5: reset in the middle of TRACK, then a clean rerun
    y = cv[0];
    start_run();
    tick();
    run_track(10, 0, -1, 0);
    chk("t5_cycles_before", cycles, 10);
    y = cv[0];
    reset = 1'b1;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_cycles", cycles, 0);
    chk("t5_rst_err", err_count, 0);
    chk("t5_rst_exp_state", exp_state, 0);
    start = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("t5_idle_busy", busy, 0);
    start_run();
    tick();
    run_track(20, 0, -1, 0);
    chk_pass("t5");

    // 6: i2 low sticks the ring at index 2; rerun after PASS
    iv = 5'b11011;
    y = cv[0];
    start_run();
    tick();
    run_track(20, 2, -1, 0);
    chk_pass("t6a");
    y = cv[0];
    start_run();
    chk("t6_pass_cleared", pass, 0);
    tick();
    run_track(20, 2, -1, 0);
    chk_pass("t6b");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
